// File: rtl/multicycle_control_if.sv
// Handshake bundle between the multicycle controller and its datapath.
// The controller takes the master view; the datapath (or a testbench) takes the slave view.
interface multicycle_control_if #(
    parameter int OPCODE_W = 4
);
    logic                instrValid;
    logic                format;
    logic [OPCODE_W-1:0] opcode;
    logic                sign;
    logic                memReady;
    logic                resume;

    logic                irWrite;
    logic                pcWrite;
    logic                regWrite;
    logic                cpin;
    logic                cpout;
    logic                memRead;
    logic                memWrite;
    logic                branch;
    logic                jump;
    logic [1:0]          writeSrc;
    logic                halt;
    logic                memError;
    logic [2:0]          state;

    modport master (
        input  instrValid, format, opcode, sign, memReady, resume,
        output irWrite, pcWrite, regWrite, cpin, cpout, memRead, memWrite,
               branch, jump, writeSrc, halt, memError, state
    );

    modport slave (
        output instrValid, format, opcode, sign, memReady, resume,
        input  irWrite, pcWrite, regWrite, cpin, cpout, memRead, memWrite,
               branch, jump, writeSrc, halt, memError, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle processor control FSM: FETCH/DECODE/EXEC/MEM/WB/HALTED with a bounded
// memory wait and a sticky memory-timeout flag.
module multicycle_control #(
    parameter int OPCODE_W    = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input logic                 clk,
    input logic                 reset,
    multicycle_control_if.master bus
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALTED = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_IMM,
        CLS_LOAD,
        CLS_STORE,
        CLS_JUMP,
        CLS_BRANCH,
        CLS_CP,
        CLS_HALT
    } class_t;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_LOAD   = 4'b0001;
    localparam logic [3:0] OP_STORE  = 4'b0010;
    localparam logic [3:0] OP_JUMP   = 4'b0011;
    localparam logic [3:0] OP_BRANCH = 4'b0100;
    localparam logic [3:0] OP_EPAR   = 4'b0101;
    localparam logic [3:0] OP_CP     = 4'b0111;
    localparam logic [3:0] OP_SHIFT  = 4'b1010;
    localparam logic [3:0] OP_HALT   = 4'b1011;

    localparam int              CNT_W    = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t              state;
    state_t              nextState;
    logic                fmtReg;
    logic                signReg;
    logic [OPCODE_W-1:0] opReg;
    logic [CNT_W-1:0]    memCount;
    logic                memErrorReg;
    class_t              instrClass;
    logic [1:0]          decodedSrc;
    logic                timeoutHit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH;
            fmtReg  <= 1'b0;
            signReg <= 1'b0;
            opReg   <= '0;
        end else begin
            state <= nextState;
            if (state == FETCH && bus.instrValid) begin
                fmtReg  <= bus.format;
                signReg <= bus.sign;
                opReg   <= bus.opcode;
            end
        end
    end

    // The wait counter is cleared on the way into MEM and counts cycles without memReady.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memCount    <= '0;
            memErrorReg <= 1'b0;
        end else begin
            if (state == EXEC) begin
                memCount <= '0;
            end else if (state == MEM && !bus.memReady) begin
                memCount <= memCount + 1'b1;
            end
            if (state == MEM && !bus.memReady && timeoutHit) begin
                memErrorReg <= 1'b1;
            end
        end
    end

    assign timeoutHit = (MEM_TIMEOUT != 0) && (memCount == CNT_LAST);

    always_comb begin
        instrClass = CLS_NOP;
        if (!fmtReg) begin
            instrClass = CLS_IMM;
        end else if ((opReg >> 4) == '0) begin
            case (opReg[3:0])
                OP_ADD, OP_EPAR, OP_SHIFT: instrClass = CLS_ALU;
                OP_LOAD:                   instrClass = CLS_LOAD;
                OP_STORE:                  instrClass = CLS_STORE;
                OP_JUMP:                   instrClass = CLS_JUMP;
                OP_BRANCH:                 instrClass = CLS_BRANCH;
                OP_CP:                     instrClass = CLS_CP;
                OP_HALT:                   instrClass = CLS_HALT;
                default:                   instrClass = CLS_NOP;
            endcase
        end
    end

    always_comb begin
        decodedSrc = 2'b00;
        case (instrClass)
            CLS_ALU: decodedSrc = 2'b11;
            CLS_IMM: decodedSrc = 2'b01;
            default: decodedSrc = 2'b00;
        endcase
    end

    // irWrite in FETCH and pcWrite on store completion are qualified by the handshake inputs
    // so the strobe lands in the same cycle as the event it acknowledges.
    always_comb begin
        nextState    = state;
        bus.irWrite  = 1'b0;
        bus.pcWrite  = 1'b0;
        bus.regWrite = 1'b0;
        bus.cpin     = 1'b0;
        bus.cpout    = 1'b0;
        bus.memRead  = 1'b0;
        bus.memWrite = 1'b0;
        bus.branch   = 1'b0;
        bus.jump     = 1'b0;
        bus.writeSrc = 2'b00;
        bus.halt     = 1'b0;
        case (state)
            FETCH: begin
                if (bus.instrValid) begin
                    bus.irWrite = !reset;
                    nextState   = DECODE;
                end
            end
            DECODE: begin
                bus.writeSrc = decodedSrc;
                nextState    = EXEC;
            end
            EXEC: begin
                bus.writeSrc = decodedSrc;
                case (instrClass)
                    CLS_ALU, CLS_IMM: nextState = WB;
                    CLS_LOAD: begin
                        bus.memRead = 1'b1;
                        nextState   = MEM;
                    end
                    CLS_STORE: begin
                        bus.memWrite = 1'b1;
                        nextState    = MEM;
                    end
                    CLS_JUMP: begin
                        bus.jump    = 1'b1;
                        bus.pcWrite = 1'b1;
                        nextState   = FETCH;
                    end
                    CLS_BRANCH: begin
                        bus.branch  = 1'b1;
                        bus.pcWrite = 1'b1;
                        nextState   = FETCH;
                    end
                    CLS_CP: begin
                        bus.cpout   = signReg;
                        bus.cpin    = !signReg;
                        bus.pcWrite = 1'b1;
                        nextState   = FETCH;
                    end
                    CLS_HALT: nextState = HALTED;
                    default: begin
                        bus.pcWrite = 1'b1;
                        nextState   = FETCH;
                    end
                endcase
            end
            MEM: begin
                bus.writeSrc = decodedSrc;
                if (bus.memReady) begin
                    if (instrClass == CLS_LOAD) begin
                        nextState = WB;
                    end else begin
                        bus.pcWrite = 1'b1;
                        nextState   = FETCH;
                    end
                end else begin
                    bus.memRead  = (instrClass == CLS_LOAD);
                    bus.memWrite = (instrClass == CLS_STORE);
                    if (timeoutHit) begin
                        nextState = HALTED;
                    end
                end
            end
            WB: begin
                bus.writeSrc = decodedSrc;
                bus.regWrite = 1'b1;
                bus.pcWrite  = 1'b1;
                nextState    = FETCH;
            end
            HALTED: begin
                bus.halt = 1'b1;
                if (bus.resume) begin
                    nextState = FETCH;
                end
            end
            default: nextState = FETCH;
        endcase
    end

    assign bus.memError = memErrorReg;
    assign bus.state    = state;

endmodule
